mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU in the RVGA pipeline.
- Consumes the ALU result `f` as either a load/store effective address or a pass-through result.
- Performs byte/half/word loads and stores over a request/ack data-memory port, with lane steering and sign/zero extension.
- Presents a registered writeback record to the next stage under a valid/ready handshake.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an op.
- in_ready  out  1  stage accepts an op this cycle.
- alu_f  in  XLEN  ALU result: address for mem ops, result otherwise.
- store_data  in  XLEN  rs2 value for stores.
- rd  in  REGW  destination register index.
- mem_op  in  4  0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw; 9-15 treated as none.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address, alu_f with [1:0] forced to 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  store data, lane-replicated.
- dmem_rdata  in  XLEN  load data, valid when dmem_ack=1.
- dmem_ack  in  1  request completes this cycle.
- out_valid  out  1  writeback record valid.
- out_ready  in  1  downstream accepts.
- out_data  out  XLEN  writeback value.
- out_rd  out  REGW  writeback register.
- out_we  out  1  register write enable.
- out_misalign  out  1  misaligned-access flag; constant 0 unless the optional feature is enabled.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every registered output is 0, including dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, out_data, out_rd, out_we and out_misalign.
- Asserting rst_n mid-transaction abandons the access; dmem_req falls immediately.
- FSM states: IDLE and MEM_WAIT.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
- Non-memory op accepted:
  - Next cycle out_valid=1, out_data=alu_f, out_rd=rd, out_we=(rd!=0).
  - Latency 1; sustains 1 op/cycle while out_ready=1.
- Memory op accepted:
  - Next cycle state=MEM_WAIT and dmem_req=1, with dmem_addr/we/be/wdata registered.
  - All request fields stay stable until dmem_ack is sampled high.
- Byte enables by op and alu_f[1:0]:
  - byte: 1<<a[1:0].
  - half: 4'b0011 if a[1]=0, else 4'b1100.
  - word: 4'b1111.
- Store data: sb replicates store_data[7:0] into all four lanes; sh replicates [15:0] into both halves; sw passes the word unchanged.
- Ack handling (in MEM_WAIT, dmem_ack=1):
  - Next cycle dmem_req=0, state=IDLE, out_valid=1.
  - Load: select the lane by the latched a[1:0]; lb/lh sign-extend, lbu/lhu zero-extend; out_we=(rd!=0).
  - Store: out_data=0, out_we=0.
  - Minimum load/store latency is 2 cycles (accept → req → result).
- dmem_ack while dmem_req=0 is ignored.
- Output hold: while out_valid && !out_ready, every out_* field is held stable.
  - out_valid clears on out_ready unless a new op is accepted in the same cycle.
  - A simultaneous out_ready and accept reloads the record back-to-back with no bubble.
- No new op is accepted while in MEM_WAIT; the stage holds at most one op.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with a[0]=1, or a word access with a[1:0]!=0, issues no memory request.
  - Instead, next cycle out_valid=1, out_misalign=1, out_we=0, out_data=alu_f (faulting address).
  - out_misalign clears when that record is consumed.
- Undefined:
  - Misaligned low bits are ignored: half uses a[1] only; word uses byte enables 4'b1111.
  - out_misalign is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → every output is 0 and in_ready=0 while in reset; after release, in_ready=1.
- ALU pass-through: alu_f=0x0000_1234, rd=5, mem_op=0, out_ready=1 → one cycle later out_valid=1, out_data=0x1234, out_rd=5, out_we=1; repeat with rd=0 → out_we=0.
- lb sign extension: alu_f=0x103, dmem_rdata=0x80FF_0000 acked on the first request cycle → dmem_addr=0x100, dmem_be=4'b1000, out_data=0xFFFF_FF80; the same access as lbu gives 0x0000_0080.
- sh: alu_f=0x202, store_data=0xAAAA_BEEF, ack delayed 3 cycles → dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF held stable for all 4 request cycles, in_ready=0 throughout, final out_we=0.
- Backpressure: out_ready=0 for 4 cycles after a result → out fields held and in_ready=0; raise out_ready with in_valid=1 → the new op is accepted in that same cycle with no bubble.
- MEM_MISALIGN_TRAP_EN defined: lw with alu_f=0x301 → no dmem_req; out_misalign=1, out_data=0x301. Undefined: the same op gives dmem_addr=0x300, dmem_be=4'b1111.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RVGA memory-access stage (loads/stores over a req/ack port, registered writeback record).
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of issuing them).
module mem_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_f,
    input  logic [XLEN-1:0] store_data,
    input  logic [REGW-1:0] rd,
    input  logic [3:0]      mem_op,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [REGW-1:0] out_rd,
    output logic            out_we,
    output logic            out_misalign
);

    typedef enum logic {IDLE, MEM_WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t state, next_state;

    logic            op_load, op_store, op_unsigned, op_misalign, op_mem_go, accept;
    size_t           op_size;
    logic [3:0]      op_be;
    logic [XLEN-1:0] op_wdata;

    logic            lat_load, lat_unsigned;
    size_t           lat_size;
    logic [1:0]      lat_lo;
    logic [REGW-1:0] lat_rd;

    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [XLEN-1:0] load_val;

    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_load     = 1'b0;
        op_store    = 1'b0;
        op_unsigned = 1'b0;
        op_size     = SZ_W;
        case (mem_op)
            4'd1: begin op_load = 1'b1;  op_size = SZ_B; end
            4'd2: begin op_load = 1'b1;  op_size = SZ_H; end
            4'd3: begin op_load = 1'b1;  op_size = SZ_W; end
            4'd4: begin op_load = 1'b1;  op_size = SZ_B; op_unsigned = 1'b1; end
            4'd5: begin op_load = 1'b1;  op_size = SZ_H; op_unsigned = 1'b1; end
            4'd6: begin op_store = 1'b1; op_size = SZ_B; end
            4'd7: begin op_store = 1'b1; op_size = SZ_H; end
            4'd8: begin op_store = 1'b1; op_size = SZ_W; end
            default: ;
        endcase
    end

    always_comb begin
        op_be    = 4'b1111;
        op_wdata = store_data;
        case (op_size)
            SZ_B: begin
                op_be    = 4'b0001 << alu_f[1:0];
                op_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                op_be    = alu_f[1] ? 4'b1100 : 4'b0011;
                op_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
        if (!op_store)
            op_wdata = '0;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign op_misalign = (op_load || op_store) &&
                         (((op_size == SZ_H) && alu_f[0]) ||
                          ((op_size == SZ_W) && (alu_f[1:0] != 2'b00)));
`else
    assign op_misalign = 1'b0;
`endif

    assign op_mem_go = (op_load || op_store) && !op_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept && op_mem_go) next_state = MEM_WAIT;
            MEM_WAIT: if (dmem_ack)            next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Lane steering uses the address low bits latched at issue time.
    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (lat_lo)
            2'd1:    lane_byte = dmem_rdata[15:8];
            2'd2:    lane_byte = dmem_rdata[23:16];
            2'd3:    lane_byte = dmem_rdata[31:24];
            default: ;
        endcase
        lane_half = lat_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_size)
            SZ_B:    load_val = lat_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SZ_H:    load_val = lat_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0;
            dmem_wdata   <= '0;
            lat_load     <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= SZ_B;
            lat_lo       <= 2'b0;
            lat_rd       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_we       <= 1'b0;
            out_misalign <= 1'b0;
        end else if (accept) begin
            if (op_mem_go) begin
                dmem_req     <= 1'b1;
                dmem_we      <= op_store;
                dmem_addr    <= {alu_f[XLEN-1:2], 2'b00};
                dmem_be      <= op_be;
                dmem_wdata   <= op_wdata;
                lat_load     <= op_load;
                lat_unsigned <= op_unsigned;
                lat_size     <= op_size;
                lat_lo       <= alu_f[1:0];
                lat_rd       <= rd;
                out_valid    <= 1'b0;
                out_misalign <= 1'b0;
            end else begin
                out_valid    <= 1'b1;
                out_data     <= alu_f;
                out_rd       <= rd;
                out_we       <= !op_misalign && (rd != '0);
                out_misalign <= op_misalign;
            end
        end else if (state == MEM_WAIT && dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            out_valid    <= 1'b1;
            out_data     <= lat_load ? load_val : '0;
            out_rd       <= lat_rd;
            out_we       <= lat_load && (lat_rd != '0);
            out_misalign <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage using immediate assertions.
// Build with +define+MEM_MISALIGN_TRAP_EN to exercise the misalignment trap path.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_f;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [3:0]  mem_op;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_misalign;

    int checks = 0;
    int passed = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_f(alu_f), .store_data(store_data), .rd(rd), .mem_op(mem_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [31:0] f, input logic [31:0] sd,
                                 input logic [4:0] r);
        in_valid   = v;
        mem_op     = op;
        alu_f      = f;
        store_data = sd;
        rd         = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b1, 4'd3, 32'h103, 32'hFFFF_FFFF, 5'd5);
        tick();
        tick();

        checkOutput("rst_dmem_req", dmem_req, 0);
        checkOutput("rst_dmem_we", dmem_we, 0);
        checkOutput("rst_dmem_addr", dmem_addr, 0);
        checkOutput("rst_dmem_be", dmem_be, 0);
        checkOutput("rst_dmem_wdata", dmem_wdata, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_rd", out_rd, 0);
        checkOutput("rst_out_we", out_we, 0);
        checkOutput("rst_out_misalign", out_misalign, 0);
        checkOutput("rst_in_ready", in_ready, 0);

        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        applyStimulus(1'b1, 4'd0, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        checkOutput("alu_out_valid", out_valid, 1);
        checkOutput("alu_out_data", out_data, 32'h1234);
        checkOutput("alu_out_rd", out_rd, 5);
        checkOutput("alu_out_we", out_we, 1);

        applyStimulus(1'b1, 4'd0, 32'h0000_5678, 32'h0, 5'd0);
        tick();
        checkOutput("alu_rd0_valid", out_valid, 1);
        checkOutput("alu_rd0_data", out_data, 32'h5678);
        checkOutput("alu_rd0_we", out_we, 0);

        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("alu_drain_valid", out_valid, 0);

        // lb from byte lane 3
        applyStimulus(1'b1, 4'd1, 32'h103, 32'h0, 5'd7);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        checkOutput("lb_req", dmem_req, 1);
        checkOutput("lb_we", dmem_we, 0);
        checkOutput("lb_addr", dmem_addr, 32'h100);
        checkOutput("lb_be", dmem_be, 4'b1000);
        checkOutput("lb_in_ready", in_ready, 0);
        dmem_rdata = 32'h80FF_0000;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("lb_req_drop", dmem_req, 0);
        checkOutput("lb_valid", out_valid, 1);
        checkOutput("lb_data", out_data, 32'hFFFF_FF80);
        checkOutput("lb_rd", out_rd, 7);
        checkOutput("lb_we_out", out_we, 1);

        applyStimulus(1'b1, 4'd4, 32'h103, 32'h0, 5'd7);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        checkOutput("lbu_req", dmem_req, 1);
        checkOutput("lbu_valid_cleared", out_valid, 0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("lbu_data", out_data, 32'h0000_0080);

        // lh from upper half, sign-extended
        applyStimulus(1'b1, 4'd2, 32'h106, 32'h0, 5'd3);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        checkOutput("lh_addr", dmem_addr, 32'h104);
        checkOutput("lh_be", dmem_be, 4'b1100);
        dmem_rdata = 32'h8001_0000;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("lh_data", out_data, 32'hFFFF_8001);

        // sh with ack on the fourth request cycle; a pending op must not be taken
        applyStimulus(1'b1, 4'd7, 32'h202, 32'hAAAA_BEEF, 5'd9);
        tick();
        applyStimulus(1'b1, 4'd0, 32'h999, 32'h0, 5'd3);
        checkOutput("sh_req_c1", dmem_req, 1);
        checkOutput("sh_we_c1", dmem_we, 1);
        checkOutput("sh_be_c1", dmem_be, 4'b1100);
        checkOutput("sh_wdata_c1", dmem_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_in_ready_c1", in_ready, 0);
        dmem_rdata = 32'hDEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("sh_req_hold", dmem_req, 1);
            checkOutput("sh_addr_hold", dmem_addr, 32'h200);
            checkOutput("sh_be_hold", dmem_be, 4'b1100);
            checkOutput("sh_wdata_hold", dmem_wdata, 32'hBEEF_BEEF);
            checkOutput("sh_in_ready_hold", in_ready, 0);
            checkOutput("sh_no_result", out_valid, 0);
        end
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("sh_req_drop", dmem_req, 0);
        checkOutput("sh_valid", out_valid, 1);
        checkOutput("sh_out_we", out_we, 0);
        checkOutput("sh_out_data", out_data, 0);
        checkOutput("sh_out_rd", out_rd, 9);

        // backpressure then same-cycle drain and reload
        applyStimulus(1'b1, 4'd0, 32'hCAFE, 32'h0, 5'd4);
        tick();
        checkOutput("bp_first_data", out_data, 32'hCAFE);
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'd0, 32'hBEEF, 32'h0, 5'd6);
        #1;
        checkOutput("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_data", out_data, 32'hCAFE);
            checkOutput("bp_hold_rd", out_rd, 4);
            checkOutput("bp_hold_we", out_we, 1);
            checkOutput("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        checkOutput("bp_reload_valid", out_valid, 1);
        checkOutput("bp_reload_data", out_data, 32'hBEEF);
        checkOutput("bp_reload_rd", out_rd, 6);
        tick();
        checkOutput("bp_drain_valid", out_valid, 0);

        // misaligned lw
        applyStimulus(1'b1, 4'd3, 32'h301, 32'h0, 5'd8);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_no_req", dmem_req, 0);
        checkOutput("mis_valid", out_valid, 1);
        checkOutput("mis_flag", out_misalign, 1);
        checkOutput("mis_data", out_data, 32'h301);
        checkOutput("mis_we", out_we, 0);
        tick();
        checkOutput("mis_flag_clear", out_misalign, 0);
        checkOutput("mis_valid_clear", out_valid, 0);
`else
        checkOutput("mis_req", dmem_req, 1);
        checkOutput("mis_addr", dmem_addr, 32'h300);
        checkOutput("mis_be", dmem_be, 4'b1111);
        dmem_rdata = 32'h1122_3344;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("mis_lw_data", out_data, 32'h1122_3344);
        checkOutput("mis_flag_zero", out_misalign, 0);
        tick();
`endif

        // stray ack with no request outstanding
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("stray_ack_valid", out_valid, 0);
        checkOutput("stray_ack_req", dmem_req, 0);

        // reset during an outstanding sw
        applyStimulus(1'b1, 4'd8, 32'h400, 32'h1234_5678, 5'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        checkOutput("sw_req", dmem_req, 1);
        checkOutput("sw_wdata", dmem_wdata, 32'h1234_5678);
        checkOutput("sw_be", dmem_be, 4'b1111);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", dmem_req, 0);
        checkOutput("midrst_wdata", dmem_wdata, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_req_after", dmem_req, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
